riscv_core_data_mem_amo_ctrl: RTL and testbench
===============================================

Name: riscv_core_data_mem_amo_ctrl

Overview:
- Sequencer in front of the core data memory port; serialises load, store, LR/SC and AMO read-modify-write requests from the LSU into memory read/write cycles.
- Holds the single LR reservation and computes AMO results.
- The LSU talks to it over a valid/ready request/response pair. It is the sole master of the data memory write enable, size, address and wdata.

Parameters:
XLEN, 64, data/address width
RSV_GRAN, 3, log2 bytes of reservation granule (address compare ignores low RSV_GRAN bits)

Ports:
i_data_mem_clk  in  1  clock
i_data_mem_rst_n  in  1  async active-low reset
i_req_valid  in  1  request valid
o_req_ready  out  1  ctrl can accept request
i_req_op  in  4  0 LOAD,1 STORE,2 LR,3 SC,4 SWAP,5 ADD,6 XOR,7 AND,8 OR,9 MIN,10 MAX,11 MINU,12 MAXU; 13-15 illegal
i_req_size  in  2  00 B,01 H,10 W,11 D
i_req_ld_extend  in  1  sign-extend load data (LOAD only)
i_req_addr  in  XLEN  byte address
i_req_wdata  in  XLEN  store data / AMO operand (rs2)
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  LSU accepts response
o_rsp_rdata  out  XLEN  load/old-memory value; SC: 0 success, 1 fail
o_rsp_err  out  1  illegal op or misaligned atomic
o_mem_w_en  out  1  to data memory write enable
o_mem_ld_extend  out  1  to data memory load extend
o_mem_r_w_size  out  2  to data memory size
o_mem_address  out  XLEN  to data memory address
o_mem_wdata  out  XLEN  to data memory write data
i_mem_rdata  in  XLEN  combinational read data from memory

Behaviour:
- Reset (i_data_mem_rst_n, asynchronous, active-low; clock i_data_mem_clk): state IDLE, reservation invalid, latched request cleared. o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, all o_mem_* = 0. o_req_ready = (state==IDLE), so it is 1 once reset is released.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: a handshake occurs when i_req_valid & o_req_ready. On handshake, latch op, size, addr, wdata, ld_extend. Next state:
  - Illegal op (13-15), or atomic (ops 2-12) with size not W/D, or atomic with addr not naturally aligned: RESP with err=1, rdata=0, no memory access, reservation unchanged.
  - LOAD, LR, AMO: READ.
  - STORE: WRITE.
  - SC: WRITE if reservation valid and addr[XLEN-1:RSV_GRAN] matches; otherwise RESP with rdata=1 (fail). Either way, SC invalidates the reservation.
- READ (1 cycle):
  - o_mem_w_en=0, size/address from the latch. o_mem_ld_extend = latched ld_extend for LOAD; 1 for LR/AMO .W; don't-care for D.
  - Capture i_mem_rdata into the old-value register.
  - LOAD: go to RESP.
  - LR: set reservation valid with address = latched addr, then RESP.
  - AMO: go to WRITE.
- WRITE (1 cycle): o_mem_w_en=1. o_mem_wdata is:
  - STORE/SC: latched wdata.
  - AMO: f(old, rs2).
    - .W: operates on bits [31:0] only. MIN/MAX are signed 32-bit, MINU/MAXU unsigned 32-bit. Only bits [31:0] are written (size=W).
    - .D: full 64-bit.
  - Any STORE/AMO write whose granule matches the reservation invalidates it.
  - Next state RESP. rdata = old value for AMO (sign-extended from 32 for .W), 0 for STORE, 0 for successful SC.
- RESP: o_rsp_valid=1 with rdata/err stable until i_rsp_ready; on handshake go to IDLE.
  - o_req_ready=0 here; there is no back-to-back overlap.
  - Outside WRITE, o_mem_w_en=0.
- Latency from accept edge to o_rsp_valid:
  - LOAD/LR: 2 cycles.
  - STORE/successful SC: 2 cycles.
  - AMO: 3 cycles.
  - Error or failed SC: 1 cycle.
- Reset mid-operation: the FSM aborts to IDLE immediately. No write commits after reset assertion, the reservation is cleared, and the pending response is dropped.
- A request presented while not in IDLE is ignored (ready=0); the requester holds it.

Optional Feature:
RISCV_AMO_MINMAX_EN
- Defined: ops 9-12 (MIN, MAX, MINU, MAXU) are executed as described above.
- Undefined: ops 9-12 are treated as illegal: RESP with err=1 and no memory access. The comparator logic is not synthesised.

Test Plan:
- Reset, then LOAD size=W, ext=1, addr=0x10 with mem[0x10..0x13]=0x80000001 -> rsp_valid 2 cycles after accept, rdata=0xFFFFFFFF80000001, w_en never high.
- STORE D addr=0x20 wdata=0x1122334455667788, then LOAD D 0x20 -> first rsp rdata=0, exactly one w_en cycle; second rdata=0x1122334455667788.
- LR D 0x40, then SC D 0x40 wdata=5 -> SC rdata=0 and mem=5. Immediate second SC to 0x40 -> rdata=1 and no w_en.
- LR D 0x40, STORE to 0x44, then SC D 0x40 -> SC rdata=1 (reservation killed by same-granule store).
- AMOADD.W 0x80 with mem=0x7FFFFFFF, rs2=1 -> rdata=0x000000007FFFFFFF, mem word=0x80000000, rsp 3 cycles after accept. AMOMAXU.D with mem=5, rs2=-1 -> mem=0xFFFFFFFFFFFFFFFF (macro defined), err=1 with mem unchanged (macro undefined).
- AMOSWAP.D addr=0x84 (misaligned) -> err=1 after 1 cycle, no w_en. Then assert reset during WRITE of a STORE -> no write commits, o_rsp_valid=0, o_req_ready=1 after release.

Source files
------------

// File: rtl/riscv_core_data_mem_amo_ctrl.sv
// riscv_core_data_mem_amo_ctrl: serialises LSU load/store/LR/SC/AMO requests into data memory read/write cycles
// Optional MIN/MAX/MINU/MAXU AMOs are enabled by defining RISCV_AMO_MINMAX_EN.
// Ports: i_data_mem_clk/i_data_mem_rst_n clock and async active-low reset;
//   i_req_* / o_req_ready LSU request handshake; o_rsp_* / i_rsp_ready LSU response handshake;
//   o_mem_* drive the data memory port, i_mem_rdata is its combinational read data.
module riscv_core_data_mem_amo_ctrl #(
  parameter int XLEN     = 64,
  parameter int RSV_GRAN = 3
) (
  input  logic            i_data_mem_clk,
  input  logic            i_data_mem_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [3:0]      i_req_op,
  input  logic [1:0]      i_req_size,
  input  logic            i_req_ld_extend,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_mem_w_en,
  output logic            o_mem_ld_extend,
  output logic [1:0]      o_mem_r_w_size,
  output logic [XLEN-1:0] o_mem_address,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic [XLEN-1:0] i_mem_rdata
);
  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LR    = 4'd2;
  localparam logic [3:0] OP_SC    = 4'd3;
  localparam logic [3:0] OP_SWAP  = 4'd4;
  localparam logic [3:0] OP_ADD   = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [1:0] SZ_W     = 2'b10;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] op_q;
  logic [1:0] size_q;
  logic ext_q, err_q, rsv_valid;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, mem_ext, rs2, amo_res, wr_data;
  logic [XLEN-1:RSV_GRAN] rsv_addr;
  logic accept, illegal, atomic, misaligned, req_err, sc_ok, rsv_hit_q, busy;
`ifdef RISCV_AMO_MINMAX_EN
  localparam logic [3:0] OP_MIN  = 4'd9;
  localparam logic [3:0] OP_MAX  = 4'd10;
  localparam logic [3:0] OP_MINU = 4'd11;
  localparam logic [3:0] OP_MAXU = 4'd12;
  logic lt, is_min;
  assign illegal = i_req_op > OP_MAXU;
  // Both operands are sign-extended for .W, which keeps signed and unsigned 32-bit ordering intact.
  assign lt      = (op_q == OP_MIN || op_q == OP_MAX) ? ($signed(rdata_q) < $signed(rs2)) : (rdata_q < rs2);
  assign is_min  = op_q == OP_MIN || op_q == OP_MINU;
`else
  assign illegal = i_req_op > OP_OR;
`endif
  assign accept     = i_req_valid & (state == IDLE);
  assign atomic     = i_req_op >= OP_LR;
  assign misaligned = i_req_size[0] ? |i_req_addr[2:0] : |i_req_addr[1:0];
  assign req_err    = illegal | (atomic & (~i_req_size[1] | misaligned));
  assign sc_ok      = rsv_valid & (rsv_addr == i_req_addr[XLEN-1:RSV_GRAN]);
  assign rsv_hit_q  = rsv_valid & (rsv_addr == addr_q[XLEN-1:RSV_GRAN]);
  // Atomic .W results are reported sign-extended from bit 31 regardless of memory extension.
  assign mem_ext    = (size_q == SZ_W && op_q != OP_LOAD) ? {{(XLEN-32){i_mem_rdata[31]}}, i_mem_rdata[31:0]} : i_mem_rdata;
  assign rs2        = size_q[0] ? wdata_q : {{(XLEN-32){wdata_q[31]}}, wdata_q[31:0]};
  always_comb begin
    amo_res = op_q == OP_SWAP ? rs2 : op_q == OP_ADD ? rdata_q + rs2 : op_q == OP_XOR ? rdata_q ^ rs2 : op_q == OP_AND ? rdata_q & rs2 : rdata_q | rs2;
`ifdef RISCV_AMO_MINMAX_EN
    if (op_q >= OP_MIN) amo_res = (is_min ? lt : ~lt) ? rdata_q : rs2;
`endif
    wr_data = (op_q == OP_STORE || op_q == OP_SC) ? wdata_q : amo_res;
  end
  always_ff @(posedge i_data_mem_clk or negedge i_data_mem_rst_n)
    if (!i_data_mem_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    busy = state == READ || state == WRITE;
    o_req_ready = state == IDLE;
    o_rsp_valid = state == RESP;
    o_rsp_rdata = o_rsp_valid ? rdata_q : '0;
    o_rsp_err = o_rsp_valid & err_q;
    o_mem_w_en = state == WRITE;
    o_mem_ld_extend = state == READ && (op_q == OP_LOAD ? ext_q : 1'b1);
    o_mem_r_w_size = busy ? size_q : 2'b00;
    o_mem_address = busy ? addr_q : '0;
    o_mem_wdata = o_mem_w_en ? wr_data : '0;
    case (state)
      IDLE:    if (accept) state_nx = req_err ? RESP : i_req_op == OP_STORE ? WRITE : i_req_op == OP_SC ? (sc_ok ? WRITE : RESP) : READ;
      READ:    state_nx = (op_q == OP_LOAD || op_q == OP_LR) ? RESP : WRITE;
      WRITE:   state_nx = RESP;
      RESP:    if (i_rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // rdata_q holds the old memory value; for AMOs it is also the first operand.
  always_ff @(posedge i_data_mem_clk or negedge i_data_mem_rst_n)
    if (!i_data_mem_rst_n) begin
      op_q      <= '0;
      size_q    <= '0;
      ext_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      rsv_valid <= 1'b0;
      rsv_addr  <= '0;
    end else begin
      if (accept) begin
        op_q    <= i_req_op;
        size_q  <= i_req_size;
        ext_q   <= i_req_ld_extend;
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wdata;
        err_q   <= req_err;
        rdata_q <= {{(XLEN-1){1'b0}}, ~req_err & (i_req_op == OP_SC) & ~sc_ok};
      end
      if (state == READ) rdata_q <= mem_ext;
      if (accept & ~req_err & (i_req_op == OP_SC)) rsv_valid <= 1'b0;
      else if (state == READ && op_q == OP_LR) begin
        rsv_valid <= 1'b1;
        rsv_addr  <= addr_q[XLEN-1:RSV_GRAN];
      end else if (state == WRITE && rsv_hit_q) rsv_valid <= 1'b0;
    end
endmodule

// File: tb/tb_riscv_core_data_mem_amo_ctrl.sv
// tb_riscv_core_data_mem_amo_ctrl: randomized and directed checks of the data memory AMO controller against a reference model
module tb_riscv_core_data_mem_amo_ctrl;
  typedef logic [81:0] pack_t;
`ifdef RISCV_AMO_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ext = 1'b0, rsp_ready = 1'b0;
  logic [3:0] req_op = '0;
  logic [1:0] req_size = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic o_req_ready, o_rsp_valid, o_rsp_err, o_mem_w_en, o_mem_ld_extend;
  logic [1:0] o_mem_r_w_size;
  logic [63:0] o_rsp_rdata, o_mem_address, o_mem_wdata, mem_rdata;
  logic [7:0] mem [512];
  logic [7:0] ref_mem [512];
  logic poke_en = 1'b0;
  logic [8:0] poke_addr = '0;
  int poke_n = 0;
  logic [63:0] poke_data = '0;
  logic ref_rsv_v = 1'b0;
  logic [63:0] ref_rsv_a = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  riscv_core_data_mem_amo_ctrl #(.XLEN(64), .RSV_GRAN(3)) dut (
    .i_data_mem_clk(clk), .i_data_mem_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_op(req_op), .i_req_size(req_size),
    .i_req_ld_extend(req_ext), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_w_en(o_mem_w_en), .o_mem_ld_extend(o_mem_ld_extend), .o_mem_r_w_size(o_mem_r_w_size),
    .o_mem_address(o_mem_address), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
  );
  always @(posedge clk)
    if (poke_en) begin
      for (int i = 0; i < 8; i++) if (i < poke_n) mem[9'(poke_addr + 9'(i))] <= poke_data[i*8+:8];
    end else if (o_mem_w_en) begin
      for (int i = 0; i < 8; i++) if (i < (1 << o_mem_r_w_size)) mem[9'(o_mem_address[8:0] + 9'(i))] <= o_mem_wdata[i*8+:8];
    end
  always_comb begin
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) if (i < (1 << o_mem_r_w_size)) v[i*8+:8] = mem[9'(o_mem_address[8:0] + 9'(i))];
    if (o_mem_ld_extend)
      v = o_mem_r_w_size == 2'd0 ? {{56{v[7]}}, v[7:0]} : o_mem_r_w_size == 2'd1 ? {{48{v[15]}}, v[15:0]} : o_mem_r_w_size == 2'd2 ? {{32{v[31]}}, v[31:0]} : v;
    mem_rdata = v;
  end
  function automatic logic [63:0] sext(input logic [63:0] v, input int n);
    int k;
    k = 64 - 8 * n;
    return 64'($signed(v << k) >>> k);
  endfunction
  function automatic logic [63:0] ref_rd(input logic [63:0] a, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*8+:8] = ref_mem[9'(a[8:0] + 9'(i))];
    return v;
  endfunction
  function automatic logic [63:0] env_rd(input logic [63:0] a, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*8+:8] = mem[9'(a[8:0] + 9'(i))];
    return v;
  endfunction
  function automatic int mem_diff();
    int d;
    d = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction
  task automatic ref_wr(input logic [63:0] a, input int n, input logic [63:0] d);
    for (int i = 0; i < n; i++) ref_mem[9'(a[8:0] + 9'(i))] = d[i*8+:8];
  endtask
  function automatic logic [63:0] amo64(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    case (op)
      4: return y;
      5: return x + y;
      6: return x ^ y;
      7: return x & y;
      8: return x | y;
      9: return $signed(x) < $signed(y) ? x : y;
      10: return $signed(x) > $signed(y) ? x : y;
      11: return x < y ? x : y;
      default: return x > y ? x : y;
    endcase
  endfunction
  function automatic logic [31:0] amo32(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      4: return y;
      5: return x + y;
      6: return x ^ y;
      7: return x & y;
      8: return x | y;
      9: return $signed(x) < $signed(y) ? x : y;
      10: return $signed(x) > $signed(y) ? x : y;
      11: return x < y ? x : y;
      default: return x > y ? x : y;
    endcase
  endfunction
  task automatic ref_exec(input logic [3:0] op, input logic [1:0] sz, input logic ext, input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] rd, output logic er, output int lat, output int wen);
    int n;
    logic [63:0] o, r;
    logic hit;
    n = 1 << sz;
    rd = '0; er = 1'b0; lat = 2; wen = 0;
    hit = ref_rsv_v && (a >> 3) == (ref_rsv_a >> 3);
    if (op > 12 || (!MM && op >= 9) || (op >= 2 && (n < 4 || a % 64'(n) != 0))) begin
      er = 1'b1; lat = 1;
      return;
    end
    o = ref_rd(a, n);
    if (op == 0) rd = (ext && n < 8) ? sext(o, n) : o;
    else if (op == 1) begin
      ref_wr(a, n, wd); wen = 1;
      if (hit) ref_rsv_v = 1'b0;
    end else if (op == 2) begin
      rd = sext(o, n); ref_rsv_v = 1'b1; ref_rsv_a = a;
    end else if (op == 3) begin
      ref_rsv_v = 1'b0;
      if (hit) begin ref_wr(a, n, wd); wen = 1; end
      else begin rd = 64'd1; lat = 1; end
    end else begin
      r = n == 8 ? amo64(op, o, wd) : {32'b0, amo32(op, o[31:0], wd[31:0])};
      ref_wr(a, n, r); rd = sext(o, n); wen = 1; lat = 3;
      if (hit) ref_rsv_v = 1'b0;
    end
  endtask
  task automatic poke(input logic [63:0] a, input int n, input logic [63:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a[8:0]; poke_n = n; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
    ref_wr(a, n, d);
  endtask
  task automatic xact(input logic [3:0] op, input logic [1:0] sz, input logic ext, input logic [63:0] a, input logic [63:0] wd,
                      output logic [63:0] rd, output logic er, output int lat, output int wen, output logic st);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_size = sz; req_ext = ext; req_addr = a; req_wdata = wd;
    n = 0;
    while (!o_req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; wen = 0;
    while (!o_rsp_valid && lat < 20) begin
      if (o_mem_w_en) wen++;
      @(posedge clk); #1;
      lat++;
    end
    rd = o_rsp_rdata; er = o_rsp_err; st = o_rsp_valid;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      if (!o_rsp_valid || o_rsp_rdata !== rd || o_rsp_err !== er || o_mem_w_en || o_req_ready) st = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (o_rsp_valid || !o_req_ready) st = 1'b0;
  endtask
  task automatic run(input logic [3:0] op, input logic [1:0] sz, input logic ext, input logic [63:0] a, input logic [63:0] wd,
                     output pack_t obs, output pack_t exp);
    logic [63:0] rd, erd;
    logic er, eer, st;
    int lat, wen, elat, ewen;
    ref_exec(op, sz, ext, a, wd, erd, eer, elat, ewen);
    xact(op, sz, ext, a, wd, rd, er, lat, wen, st);
    obs = {rd, er, 8'(lat), 8'(wen), st};
    exp = {erd, eer, 8'(elat), 8'(ewen), 1'b1};
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) poke(64'(i * 8), 8, {$urandom, $urandom});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata, o_mem_w_en, o_mem_ld_extend, o_mem_r_w_size, o_mem_address, o_mem_wdata} !== {1'b1, 198'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b err=%b rdata=%h w_en=%b addr=%h, expected ready=1 and all else 0", o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata, o_mem_w_en, o_mem_address);
    end
  endtask
  task automatic test_load();
    pack_t obs, exp;
    poke(64'h10, 4, 64'h80000001);
    run(4'd0, 2'd2, 1'b1, 64'h10, 64'd0, obs, exp);
    checks++;
    if (obs !== exp || obs[81:18] !== 64'hFFFFFFFF80000001) begin
      errors++; $display("FAIL load_w_ext: got %h expected %h", obs, exp);
    end
    for (int i = 0; i < 6; i++) begin
      run(4'd0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 64'($urandom_range(0, 511)), 64'd0, obs, exp);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL load_rand%0d: got %h expected %h", i, obs, exp); end
    end
  endtask
  task automatic test_store_load();
    pack_t obs, exp;
    run(4'd1, 2'd3, 1'b0, 64'h20, 64'h1122334455667788, obs, exp);
    checks++;
    if (obs !== exp || obs[81:18] !== 64'd0 || obs[8:1] !== 8'd1) begin errors++; $display("FAIL store_d: got %h expected %h", obs, exp); end
    run(4'd0, 2'd3, 1'b0, 64'h20, 64'd0, obs, exp);
    checks++;
    if (obs !== exp || obs[81:18] !== 64'h1122334455667788) begin errors++; $display("FAIL load_after_store: got %h expected %h", obs, exp); end
    checks++;
    if (mem_diff() != 0) begin errors++; $display("FAIL store_mem: got %0d differing bytes, expected 0", mem_diff()); end
  endtask
  task automatic test_lr_sc();
    pack_t obs, exp;
    run(4'd2, 2'd3, 1'b0, 64'h40, 64'd0, obs, exp);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lr_d: got %h expected %h", obs, exp); end
    run(4'd3, 2'd3, 1'b0, 64'h40, 64'd5, obs, exp);
    checks++;
    if (obs !== exp || obs[81:18] !== 64'd0 || env_rd(64'h40, 8) !== 64'd5) begin
      errors++; $display("FAIL sc_ok: got %h mem=%h expected %h mem=5", obs, env_rd(64'h40, 8), exp);
    end
    run(4'd3, 2'd3, 1'b0, 64'h40, 64'd7, obs, exp);
    checks++;
    if (obs !== exp || obs[81:18] !== 64'd1 || obs[8:1] !== 8'd0) begin errors++; $display("FAIL sc_again: got %h expected %h", obs, exp); end
  endtask
  task automatic test_rsv_kill();
    pack_t obs, exp;
    run(4'd2, 2'd3, 1'b0, 64'h40, 64'd0, obs, exp);
    run(4'd1, 2'd2, 1'b0, 64'h44, 64'hCAFE, obs, exp);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL kill_store: got %h expected %h", obs, exp); end
    run(4'd3, 2'd3, 1'b0, 64'h40, 64'd9, obs, exp);
    checks++;
    if (obs !== exp || obs[81:18] !== 64'd1) begin errors++; $display("FAIL sc_killed: got %h expected %h", obs, exp); end
    checks++;
    if (mem_diff() != 0) begin errors++; $display("FAIL kill_mem: got %0d differing bytes, expected 0", mem_diff()); end
  endtask
  task automatic test_amo();
    pack_t obs, exp;
    poke(64'h80, 4, 64'h7FFFFFFF);
    run(4'd5, 2'd2, 1'b0, 64'h80, 64'd1, obs, exp);
    checks++;
    if (obs !== exp || obs[81:18] !== 64'h7FFFFFFF || obs[16:9] !== 8'd3 || env_rd(64'h80, 4) !== 64'h80000000) begin
      errors++; $display("FAIL amoadd_w: got %h mem=%h expected %h mem=80000000", obs, env_rd(64'h80, 4), exp);
    end
    poke(64'h88, 8, 64'd5);
    run(4'd12, 2'd3, 1'b0, 64'h88, 64'hFFFFFFFFFFFFFFFF, obs, exp);
    checks++;
    if (obs !== exp || obs[17] !== !MM || env_rd(64'h88, 8) !== (MM ? 64'hFFFFFFFFFFFFFFFF : 64'd5)) begin
      errors++; $display("FAIL amomaxu_d: got %h mem=%h expected %h", obs, env_rd(64'h88, 8), exp);
    end
    for (int op = 4; op <= 12; op++)
      for (int s = 2; s <= 3; s++) begin
        poke(64'h180, 8, {$urandom, $urandom});
        run(4'(op), 2'(s), 1'b0, 64'h180, {$urandom, $urandom}, obs, exp);
        checks++;
        if (obs !== exp || mem_diff() != 0) begin errors++; $display("FAIL amo_op%0d_sz%0d: got %h expected %h diff=%0d", op, s, obs, exp, mem_diff()); end
      end
  endtask
  task automatic test_errors();
    pack_t obs, exp;
    run(4'd4, 2'd3, 1'b0, 64'h84, 64'd3, obs, exp);
    checks++;
    if (obs !== exp || obs[17] !== 1'b1 || obs[16:9] !== 8'd1 || obs[8:1] !== 8'd0) begin errors++; $display("FAIL swap_misaligned: got %h expected %h", obs, exp); end
    run(4'd14, 2'd3, 1'b0, 64'h80, 64'd3, obs, exp);
    checks++;
    if (obs !== exp || obs[17] !== 1'b1) begin errors++; $display("FAIL illegal_op: got %h expected %h", obs, exp); end
    run(4'd5, 2'd1, 1'b0, 64'h80, 64'd3, obs, exp);
    checks++;
    if (obs !== exp || obs[17] !== 1'b1) begin errors++; $display("FAIL amo_size_h: got %h expected %h", obs, exp); end
    checks++;
    if (mem_diff() != 0) begin errors++; $display("FAIL err_mem: got %0d differing bytes, expected 0", mem_diff()); end
  endtask
  task automatic test_random();
    pack_t obs, exp;
    logic [63:0] a;
    for (int i = 0; i < 80; i++) begin
      a = 64'h100 + 64'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
      run(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, obs, exp);
      checks++;
      if (obs !== exp || mem_diff() != 0) begin errors++; $display("FAIL random%0d: got %h expected %h diff=%0d", i, obs, exp, mem_diff()); end
    end
  endtask
  task automatic test_reset_mid_op();
    pack_t obs, exp;
    run(4'd2, 2'd3, 1'b0, 64'h100, 64'd0, obs, exp);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pre_reset_lr: got %h expected %h", obs, exp); end
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd1; req_size = 2'd3; req_addr = 64'h140; req_wdata = 64'hDEADBEEFDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (o_mem_w_en !== 1'b1) begin errors++; $display("FAIL store_in_write: got w_en=%b expected 1", o_mem_w_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_rsp_valid, o_mem_w_en, o_mem_address, o_mem_wdata} !== 130'b0) begin
      errors++; $display("FAIL reset_abort: got valid=%b w_en=%b addr=%h wdata=%h expected all 0", o_rsp_valid, o_mem_w_en, o_mem_address, o_mem_wdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_rsv_v = 1'b0;
    #1;
    checks++;
    if ({o_req_ready, o_rsp_valid} !== 2'b10) begin errors++; $display("FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0", o_req_ready, o_rsp_valid); end
    checks++;
    if (mem_diff() != 0) begin errors++; $display("FAIL reset_no_write: got %0d differing bytes, expected 0", mem_diff()); end
    run(4'd3, 2'd3, 1'b0, 64'h100, 64'd1, obs, exp);
    checks++;
    if (obs !== exp || obs[81:18] !== 64'd1) begin errors++; $display("FAIL sc_after_reset: got %h expected %h", obs, exp); end
  endtask
  initial begin
    test_reset();
    test_load();
    test_store_load();
    test_lr_sc();
    test_rsv_kill();
    test_amo();
    test_errors();
    test_random();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
